// File: rtl/ospi_host_ctrl.sv
// ospi_host_ctrl: single-byte OSPI host controller.
// Each frame is an opcode byte, ADDR_BYTES address bytes (MSB first), and then one of:
// a write data byte, DUMMY_CYCLES dummy periods plus a read data byte, or nothing (erase).
// One OSPI_CLK period spans two clk cycles: cycle A drives OSPI_CLK low, cycle B drives it high.
// The reserved opcode produces no frame. It only returns an error response.
module ospi_host_ctrl #(
  parameter int WIDTH        = 8,
  parameter int ADDR_BYTES   = 1,
  parameter int DUMMY_CYCLES = 4,
  parameter int CS_IDLE      = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [8*ADDR_BYTES-1:0] cmd_addr,
  input  logic [WIDTH-1:0]        cmd_wdata,
  output logic                    rsp_valid,
  output logic [WIDTH-1:0]        rsp_rdata,
  output logic                    rsp_err,
  output logic                    OSPI_CLK,
  output logic                    OSPI_CS,
  output logic [WIDTH-1:0]        OSPI_IO_O,
  output logic                    OSPI_IO_OE,
  input  logic [WIDTH-1:0]        OSPI_IO_I
);

  localparam int AW = 8 * ADDR_BYTES;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [15:0] ADDR_LAST  = 16'(ADDR_BYTES - 1);
  localparam logic [15:0] DUMMY_LAST = (DUMMY_CYCLES > 0) ? 16'(DUMMY_CYCLES - 1) : 16'd0;
  localparam logic [15:0] GAP_LAST   = (CS_IDLE > 1) ? 16'(CS_IDLE - 1) : 16'd0;

  logic [2:0]       state;
  // ph selects the half of the OSPI_CLK period: 0 is cycle A (clock low), 1 is cycle B (clock high).
  logic             ph;
  // cnt is shared. It counts address bytes, dummy periods and gap cycles, depending on the state.
  logic [15:0]      cnt;
  logic [1:0]       op_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             err_q;
  logic             cs_active;
  logic [WIDTH-1:0] tx_byte;

  // Frame sequencer: accepts a command, then steps through the frame phases period by period.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      ph      <= 1'b0;
      cnt     <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q    <= cmd_op;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            ph      <= 1'b0;
            cnt     <= '0;
            if (cmd_op == OP_RSVD) begin
              // A reserved opcode skips the bus entirely.
              // It spends one GAP cycle to raise the error response.
              err_q   <= 1'b1;
              rdata_q <= '0;
              state   <= S_GAP;
            end else begin
              err_q <= 1'b0;
              state <= S_CMD;
            end
          end
        end
        S_CMD: begin
          ph <= ~ph;
          if (ph) begin
            cnt   <= '0;
            state <= S_ADDR;
          end
        end
        S_ADDR: begin
          ph <= ~ph;
          if (ph) begin
            // Shift the next address byte into the MSB position, where it is driven from.
            addr_q <= addr_q << 8;
            if (cnt == ADDR_LAST) begin
              cnt <= '0;
              case (op_q)
                OP_READ:  state <= (DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;
                OP_WRITE: state <= S_DATA;
                default: begin
                  rdata_q <= '0;
                  state   <= S_GAP;
                end
              endcase
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_DUMMY: begin
          ph <= ~ph;
          if (ph) begin
            if (cnt == DUMMY_LAST) begin
              cnt   <= '0;
              state <= S_DATA;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_DATA: begin
          ph <= ~ph;
          if (ph) begin
            // Read data is sampled on the edge that closes cycle B, at the end of the last clock-high half.
            rdata_q <= (op_q == OP_READ) ? OSPI_IO_I : '0;
            cnt     <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (err_q || cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Byte driven onto the bus in the current phase.
  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    tx_byte = '0;
    case (state)
      S_CMD: begin
        case (op_q)
          OP_READ:  tx_byte = WIDTH'(8'h03);
          OP_WRITE: tx_byte = WIDTH'(8'h02);
          default:  tx_byte = WIDTH'(8'h20);
        endcase
      end
      S_ADDR: tx_byte = WIDTH'(addr_q[AW-1 -: 8]);
      S_DATA: tx_byte = wdata_q;
      default: tx_byte = '0;
    endcase
  end

  // Bus and handshake outputs decode directly from state, so reset forces them idle immediately.
  always_comb begin
    cs_active  = (state == S_CMD) || (state == S_ADDR) || (state == S_DUMMY) || (state == S_DATA);
    OSPI_CS    = ~cs_active;
    OSPI_CLK   = cs_active & ph;
    OSPI_IO_OE = (state == S_CMD) || (state == S_ADDR) || ((state == S_DATA) && (op_q == OP_WRITE));
    OSPI_IO_O  = OSPI_IO_OE ? tx_byte : '0;
    cmd_ready  = (state == S_IDLE) && reset_n;
    rsp_valid  = (state == S_GAP) && (cnt == 16'd0);
    rsp_err    = rsp_valid & err_q;
    rsp_rdata  = rdata_q;
  end

endmodule

// File: tb/tb_ospi_host_ctrl.sv
// tb_ospi_host_ctrl: directed bench for ospi_host_ctrl with default parameters.
// On each command acceptance, a reference model expands the command into the exact per-cycle
// bus and response pattern. A negedge compare process checks the DUT against that pattern.
// The model also supplies the flash read data.
module tb_ospi_host_ctrl;

  localparam int DUMMY = 4;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       ospi_clk;
  logic       ospi_cs;
  logic [7:0] ospi_io_o;
  logic       ospi_io_oe;
  logic [7:0] io_i = 8'h00;

  ospi_host_ctrl #(.WIDTH(8), .ADDR_BYTES(1), .DUMMY_CYCLES(DUMMY), .CS_IDLE(GAP)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .OSPI_CLK(ospi_clk), .OSPI_CS(ospi_cs), .OSPI_IO_O(ospi_io_o),
    .OSPI_IO_OE(ospi_io_oe), .OSPI_IO_I(io_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       cs;
    logic       sclk;
    logic       oe;
    logic [7:0] io;
    logic       rdy;
    logic       rv;
    logic       re;
    logic [7:0] rd;
    logic [7:0] fl;
  } rec_t;

  rec_t       q[$];
  logic [7:0] held = 8'h00;
  logic [7:0] flash_byte = 8'h00;
  int         acc_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  int         low_run = 0;
  int         hi_run = 0;
  int         last_low = 0;
  int         frames = 0;
  int         min_gap = 9999;
  int         rsp_cnt = 0;
  logic [7:0] last_rd = 8'h00;
  logic       last_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One OSPI_CLK period, seen as two cycles on the bus.
  task automatic add_period(input logic [7:0] io, input logic oe, input logic [7:0] fl);
    q.push_back('{cs: 1'b0, sclk: 1'b0, oe: oe, io: oe ? io : 8'h00, rdy: 1'b0, rv: 1'b0, re: 1'b0, rd: held, fl: fl});
    q.push_back('{cs: 1'b0, sclk: 1'b1, oe: oe, io: oe ? io : 8'h00, rdy: 1'b0, rv: 1'b0, re: 1'b0, rd: held, fl: fl});
  endtask

  // Expand an accepted command into its expected cycle sequence.
  task automatic build(input logic [1:0] op, input logic [7:0] a, input logic [7:0] w, input logic [7:0] fb);
    logic [7:0] opc;
    logic [7:0] nrd;
    if (op == 2'b11) begin
      q.push_back('{cs: 1'b1, sclk: 1'b0, oe: 1'b0, io: 8'h00, rdy: 1'b0, rv: 1'b1, re: 1'b1, rd: 8'h00, fl: 8'h77});
      held = 8'h00;
      return;
    end
    opc = (op == 2'b00) ? 8'h03 : (op == 2'b01) ? 8'h02 : 8'h20;
    add_period(opc, 1'b1, 8'h99);
    add_period(a, 1'b1, 8'h99);
    if (op == 2'b01) add_period(w, 1'b1, 8'h99);
    if (op == 2'b00) begin
      for (int i = 0; i < DUMMY; i++) add_period(8'h00, 1'b0, 8'h5C);
      add_period(8'h00, 1'b0, fb);
    end
    nrd = (op == 2'b00) ? fb : 8'h00;
    for (int i = 0; i < GAP; i++)
      q.push_back('{cs: 1'b1, sclk: 1'b0, oe: 1'b0, io: 8'h00, rdy: 1'b0, rv: (i == 0), re: 1'b0, rd: nrd, fl: 8'h77});
    held = nrd;
  endtask

  // Per-cycle compare against the model, acceptance tracking, and frame measurements.
  always @(negedge clk) begin
    rec_t e;
    if (reset_n) begin
      if (q.size() != 0) e = q.pop_front();
      else e = '{cs: 1'b1, sclk: 1'b0, oe: 1'b0, io: 8'h00, rdy: 1'b1, rv: 1'b0, re: 1'b0, rd: held, fl: 8'h00};
      check("bus{cs,clk,oe,io}", {21'd0, ospi_cs, ospi_clk, ospi_io_oe, ospi_io_o}, {21'd0, e.cs, e.sclk, e.oe, e.io});
      check("rsp{ready,valid,err,rdata}", {21'd0, cmd_ready, rsp_valid, rsp_err, rsp_rdata}, {21'd0, e.rdy, e.rv, e.re, e.rd});
      io_i = e.fl;
      if (e.rdy && cmd_valid) begin
        build(cmd_op, cmd_addr, cmd_wdata, flash_byte);
        acc_cnt++;
      end
      if (!ospi_cs) begin
        if (hi_run > 0 && frames > 0 && hi_run < min_gap) min_gap = hi_run;
        hi_run = 0;
        low_run++;
      end else begin
        if (low_run > 0) begin
          last_low = low_run;
          frames++;
        end
        low_run = 0;
        hi_run++;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        last_rd = rsp_rdata;
        last_err = rsp_err;
      end
    end
  end

  // Present a command and hold it until the model sees it accepted. Call at posedge+1.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] w, input logic [7:0] f);
    int start;
    start      = acc_cnt;
    flash_byte = f;
    cmd_op     = op;
    cmd_addr   = a;
    cmd_wdata  = w;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 200 && acc_cnt == start; i++) @(posedge clk);
    check("accept_timeout", acc_cnt != start, 1);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
    check("drain_timeout", q.size() == 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    int f0;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    #12;
    check("reset_bus", {ospi_cs, ospi_clk, ospi_io_oe, ospi_io_o}, {1'b1, 1'b0, 1'b0, 8'h00});
    check("reset_rsp", {cmd_ready, rsp_valid, rsp_err, rsp_rdata}, 11'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check("ready_after_reset", cmd_ready, 1);
    @(posedge clk);
    #1;

    // Write 0x5A <- 0xC3.
    r0 = rsp_cnt;
    issue(2'b01, 8'h5A, 8'hC3, 8'h00);
    wait_idle();
    check("write_cs_low_len", last_low, 6);
    check("write_rsp_count", rsp_cnt - r0, 1);
    check("write_rsp_err", last_err, 0);

    // Read 0x10, flash returns 0xA5.
    r0 = rsp_cnt;
    issue(2'b00, 8'h10, 8'h00, 8'hA5);
    wait_idle();
    check("read_cs_low_len", last_low, 14);
    check("read_rsp_count", rsp_cnt - r0, 1);
    check("read_rdata", last_rd, 8'hA5);

    // Erase 0xFF.
    r0 = rsp_cnt;
    issue(2'b10, 8'hFF, 8'h00, 8'h00);
    wait_idle();
    check("erase_cs_low_len", last_low, 4);
    check("erase_rdata", last_rd, 8'h00);

    // Reserved opcode: no frame, error response.
    r0 = rsp_cnt;
    f0 = frames;
    issue(2'b11, 8'h44, 8'h00, 8'h00);
    wait_idle();
    check("rsvd_no_frame", frames - f0, 0);
    check("rsvd_rsp_count", rsp_cnt - r0, 1);
    check("rsvd_rsp_err", last_err, 1);

    // Back-to-back reads with cmd_valid held high.
    r0 = acc_cnt;
    min_gap = 9999;
    flash_byte = 8'h3C;
    cmd_op = 2'b00;
    cmd_addr = 8'h77;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && acc_cnt < r0 + 2; i++) @(posedge clk);
    check("b2b_accept_timeout", acc_cnt - r0, 2);
    #1 cmd_valid = 1'b0;
    wait_idle();
    check("b2b_cs_gap_ge2", min_gap >= 2, 1);
    check("b2b_rdata", last_rd, 8'h3C);

    // Reset in the DUMMY phase, during a clock-high half.
    r0 = acc_cnt;
    flash_byte = 8'hE1;
    cmd_op = 2'b00;
    cmd_addr = 8'h21;
    cmd_valid = 1'b1;
    @(posedge clk);
    check("rst_read_accepted", acc_cnt - r0, 1);
    #1 cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("dummy_phase_bus", {ospi_cs, ospi_clk, ospi_io_oe}, {1'b0, 1'b1, 1'b0});
    r0 = rsp_cnt;
    reset_n = 1'b0;
    q.delete();
    held = 8'h00;
    #1;
    check("inflight_reset_bus", {ospi_cs, ospi_clk, ospi_io_oe, ospi_io_o}, {1'b1, 1'b0, 1'b0, 8'h00});
    check("inflight_reset_rsp", {cmd_ready, rsp_valid, rsp_err, rsp_rdata}, 11'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    low_run = 0;
    hi_run = 0;
    issue(2'b01, 8'hA0, 8'h3E, 8'h00);
    wait_idle();
    check("post_reset_rsp_count", rsp_cnt - r0, 1);
    check("post_reset_cs_low_len", last_low, 6);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
